// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with autonomous N-shift burst engine.
// Define USR_PARITY_EN to add the par output (XOR-reduction of q).
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             par
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [2:0] bmode, bmode_n;
  logic [CNT_W-1:0] count, count_n;
  function automatic logic [WIDTH-1:0] apply(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                             input logic sl, input logic sr);
    case (m)
      3'b001:  return {v[WIDTH-2:0], sr};
      3'b010:  return {sl, v[WIDTH-1:1]};
      3'b011:  return {v[WIDTH-2:0], v[WIDTH-1]};
      3'b100:  return {v[0], v[WIDTH-1:1]};
      3'b101:  return d;
      3'b110:  return '0;
      3'b111:  return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return v;
    endcase
  endfunction
  function automatic logic is_shift(input logic [2:0] m);
    return !(m == 3'b000 || m == 3'b101 || m == 3'b110);
  endfunction
  always_comb begin
    state_n = state;
    q_n = q;
    bmode_n = bmode;
    count_n = count;
    case (state)
      IDLE:
        if (start && is_shift(mode)) begin
          bmode_n = mode;
          count_n = nshift;
          state_n = (nshift != '0) ? BUSY : DONE;
        end else if (en) q_n = apply(mode, q, sin_l, sin_r);
      BUSY:
        if (en) begin
          q_n = apply(bmode, q, sin_l, sin_r);
          count_n = count - 1'b1;
          state_n = (count == 1) ? DONE : BUSY;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q <= '0;
      bmode <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      q <= q_n;
      bmode <= bmode_n;
      count <= count_n;
    end
  end
  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign busy = (state == BUSY);
  assign done = (state == DONE);
`ifdef USR_PARITY_EN
  assign par = ^q;
`endif
endmodule
